// File: rtl/debug_event_packer.sv
// Change-detect tap consumer: timestamps trigger events into a FIFO and drains them
// as framed byte packets (A5, n, n x {tsH,tsL,data}, drop count) on a valid/ready stream.
module debug_event_packer #(
  parameter int DEPTH            = 16,
  parameter int EVENTS_PER_FRAME = 8,
  parameter int FLUSH_CYCLES     = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [7:0] data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(FLUSH_CYCLES);
  localparam logic [AW:0] EPF_C   = (AW+1)'(EVENTS_PER_FRAME);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, HDR, CNT, EV_TSH, EV_TSL, EV_DAT, TRL} state_e;

  typedef struct packed {
    logic [15:0] ts;
    logic [7:0]  val;
  } event_t;

  state_e        state_q, state_d;
  logic [15:0]   ts_q;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    n_q, n_d, rem_q, rem_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d, snap_q, snap_d;
  logic          overflow_q;
  event_t        mem [DEPTH];

  logic [AW:0]   count;
  logic          full, empty, push, drop, pop, accept, start;
  logic [7:0]    nsel, drop_base;
  event_t        head;

  assign count  = wr_ptr_q - rd_ptr_q;
  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);
  assign push   = trigger && !full;
  assign drop   = trigger && full;
  assign accept = tx_valid && tx_ready;
  assign pop    = (state_q == EV_DAT) && accept;
  assign head   = mem[rd_ptr_q[AW-1:0]];
  assign start  = (state_q == IDLE) &&
                  ((count >= EPF_C) || (timer_q == TW'(FLUSH_CYCLES - 1)));
  assign nsel   = (count >= EPF_C) ? 8'(EVENTS_PER_FRAME) : 8'(count);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    rem_d      = rem_q;
    snap_d     = snap_q;
    timer_d    = '0;
    drop_base  = (state_q == TRL && accept) ? 8'd0 : drop_cnt_q;
    drop_cnt_d = drop_base;
    if (drop && drop_base != 8'hFF) drop_cnt_d = drop_base + 8'd1;
    if (state_q == IDLE && !empty && !start) timer_d = timer_q + 1'b1;
    case (state_q)
      IDLE: if (start) begin
        state_d = HDR;
        n_d     = nsel;
        rem_d   = nsel;
      end
      HDR:    if (accept) state_d = CNT;
      CNT:    if (accept) state_d = EV_TSH;
      EV_TSH: if (accept) state_d = EV_TSL;
      EV_TSL: if (accept) state_d = EV_DAT;
      EV_DAT: if (accept) begin
        rem_d = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
          state_d = TRL;
          // Freeze the trailer value so it stays stable while the sink stalls.
          snap_d  = drop_cnt_d;
        end else begin
          state_d = EV_TSH;
        end
      end
      TRL:     if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      HDR:     tx_data = 8'hA5;
      CNT:     tx_data = n_q;
      EV_TSH:  tx_data = head.ts[15:8];
      EV_TSL:  tx_data = head.ts[7:0];
      EV_DAT:  tx_data = head.val;
      TRL:     tx_data = snap_q;
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid = (state_q != IDLE);
  assign tx_last  = (state_q == TRL);
  assign overflow = overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      timer_q    <= '0;
      n_q        <= '0;
      rem_q      <= '0;
      drop_cnt_q <= '0;
      snap_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_q + 16'd1;
      timer_q    <= timer_d;
      n_q        <= n_d;
      rem_q      <= rem_d;
      drop_cnt_q <= drop_cnt_d;
      snap_q     <= snap_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= '{ts: ts_q, val: data};
  end

endmodule
